framebuffer_pixel_reader: RTL

//  Read-side counterpart of the drawing engines' write path into the frame buffer.

---
 rtl/framebuffer_pixel_reader_pkg.sv | 51 +++++
 rtl/framebuffer_pixel_reader_fifo.sv | 57 +++++
 rtl/framebuffer_pixel_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/framebuffer_pixel_reader_pkg.sv
// Shared frame-buffer constants, FSM states and the pixel-to-word address helper.
// 8 pixels of 12 bits are packed little-endian into each group of 3 words.
package fb_pkg;

    localparam int unsigned H_RES        = 640;
    localparam int unsigned V_RES        = 480;
    localparam int unsigned IN_DEPTH     = 4;
    localparam int unsigned IN_LOG2DEPTH = 2;
    localparam logic [3:0]  RD_OP        = 4'h0;
    localparam int unsigned FB_ADDR_W    = 17;
    localparam int unsigned PX_W         = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_OUT
    } fb_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] base;
        logic [2:0]           off;
    } px_loc_t;

    // y*640 is built from two shifts so no multiplier is inferred.
    function automatic px_loc_t fb_pixel_addr(input logic [9:0] x, input logic [9:0] y);
        px_loc_t              loc;
        logic [18:0]          p;
        logic [FB_ADDR_W-1:0] grp;
        p        = (19'(y) << 9) + (19'(y) << 7) + 19'(x);
        grp      = FB_ADDR_W'(p[18:3]);
        loc.base = (grp << 1) + grp;
        loc.off  = p[2:0];
        return loc;
    endfunction

    function automatic logic [1:0] first_word_idx(input logic [2:0] off);
        case (off)
            3'd0, 3'd1, 3'd2: return 2'd0;
            3'd3, 3'd4, 3'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic is_straddle(input logic [2:0] off);
        return (off == 3'd2) || (off == 3'd5);
    endfunction

endpackage

// File: rtl/framebuffer_pixel_reader_fifo.sv
// Generic power-of-two request fifo with show-ahead read data.
// not_full / not_empty act as the ready / valid of each side.
module framebuffer_pixel_reader_fifo #(
    parameter int WIDTH     = 20,
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             not_full,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    input  logic             rd_en
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG2DEPTH-1:0] wr_ptr;
    logic [LOG2DEPTH-1:0] rd_ptr;
    logic [LOG2DEPTH:0]   count;
    logic                 push;
    logic                 pop;

    assign not_full  = (count != (LOG2DEPTH+1)'(DEPTH));
    assign not_empty = (count != '0);
    assign push      = wr_en & not_full;
    assign pop       = rd_en & not_empty;
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/framebuffer_pixel_reader.sv
// Pixel read engine: (x,y) request -> one or two arbiter word reads -> {x,y,color}.
// Only one arbiter read is ever outstanding; the first bcast_xfc in a WAIT state is ours.
//
//  state | meaning
//  IDLE  | waiting for a queued request; pops it and latches x, y, address
//  REQ0  | arb_rts for the first word, held until granted
//  WAIT0 | first word in flight; captured on bcast_xfc
//  REQ1  | arb_rts for the second word of a straddling pixel
//  WAIT1 | second word in flight; captured on bcast_xfc
//  OUT   | out_px presented, held until out_rtr
module framebuffer_pixel_reader
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic [19:0] in_req,
    input  logic        in_rts,
    output logic        in_rtr,
    output logic [31:0] out_px,
    output logic        out_rts,
    input  logic        out_rtr,
    output logic [16:0] arb_addr_out,
    output logic        arb_rts,
    input  logic        arb_rtr,
    output logic [3:0]  wr_op,
    input  logic        bcast_xfc,
    input  logic [31:0] arb_data_in
);

    logic [19:0]          fifo_data;
    logic                 fifo_valid;
    logic                 pop;
    logic [9:0]           req_x;
    logic [9:0]           req_y;
    logic                 req_oob;
    px_loc_t              req_loc;

    fb_state_t            state;
    fb_state_t            state_nxt;

    logic [9:0]           x_q;
    logic [9:0]           y_q;
    logic [2:0]           off_q;
    logic                 straddle_q;
    logic                 oob_q;
    logic [FB_ADDR_W-1:0] addr_q;
    logic [31:0]          d0_q;
    logic [7:0]           d1_q;
    logic [PX_W-1:0]      color;

    framebuffer_pixel_reader_fifo #(
        .WIDTH     (20),
        .DEPTH     (IN_DEPTH),
        .LOG2DEPTH (IN_LOG2DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .wr_data   (in_req),
        .wr_en     (in_rts),
        .not_full  (in_rtr),
        .rd_data   (fifo_data),
        .not_empty (fifo_valid),
        .rd_en     (pop)
    );

    assign req_x   = fifo_data[19:10];
    assign req_y   = fifo_data[9:0];
    assign req_oob = (req_x >= 10'(H_RES)) || (req_y >= 10'(V_RES));
    assign req_loc = fb_pixel_addr(req_x, req_y);

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fifo_valid) state_nxt = req_oob ? ST_OUT : ST_REQ0;
            ST_REQ0:  if (arb_rtr)    state_nxt = ST_WAIT0;
            ST_WAIT0: if (bcast_xfc)  state_nxt = straddle_q ? ST_REQ1 : ST_OUT;
            ST_REQ1:  if (arb_rtr)    state_nxt = ST_WAIT1;
            ST_WAIT1: if (bcast_xfc)  state_nxt = ST_OUT;
            ST_OUT:   if (out_rtr)    state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop     = (state == ST_IDLE) && fifo_valid;
        arb_rts = (state == ST_REQ0) || (state == ST_REQ1);
        out_rts = (state == ST_OUT);
        wr_op   = arb_rts ? RD_OP : 4'h0;
    end

    // The address register advances to the second word once the first arrives.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            x_q        <= '0;
            y_q        <= '0;
            off_q      <= '0;
            straddle_q <= 1'b0;
            oob_q      <= 1'b0;
            addr_q     <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_valid) begin
                        x_q        <= req_x;
                        y_q        <= req_y;
                        off_q      <= req_loc.off;
                        straddle_q <= is_straddle(req_loc.off);
                        oob_q      <= req_oob;
                        if (!req_oob) begin
                            addr_q <= req_loc.base + FB_ADDR_W'(first_word_idx(req_loc.off));
                        end
                    end
                end
                ST_WAIT0: begin
                    if (bcast_xfc) begin
                        d0_q <= arb_data_in;
                        if (straddle_q) begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (bcast_xfc) begin
                        d1_q <= arb_data_in[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // d0 is always the lower-addressed word read, d1 the straddle continuation.
    always_comb begin
        color = '0;
        if (!oob_q) begin
            case (off_q)
                3'd0: color = d0_q[11:0];
                3'd1: color = d0_q[23:12];
                3'd2: color = {d1_q[3:0], d0_q[31:24]};
                3'd3: color = d0_q[15:4];
                3'd4: color = d0_q[27:16];
                3'd5: color = {d1_q[7:0], d0_q[31:28]};
                3'd6: color = d0_q[19:8];
                3'd7: color = d0_q[31:20];
                default: color = '0;
            endcase
        end
    end

    assign out_px       = {x_q, y_q, color};
    assign arb_addr_out = addr_q;

endmodule
